// File: rtl/handshaking_master_pkg.sv
// Shared types and helpers for the handshake source and its FIFO.
// Package hs_pkg: default data width, FSM state enum, count-width helper.
package hs_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } hs_state_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/handshaking_master_if.sv
// Valid/ready handshake bundle between a source and a sink stage.
// master drives data/valid, slave drives ready.
interface handshaking_master_if
    import hs_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
);

    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_in;

    modport master (
        output data_out,
        output valid_out,
        input  ready_in
    );

    modport slave (
        input  data_out,
        input  valid_out,
        output ready_in
    );

endinterface

// File: rtl/handshaking_master_fifo.sv
// hs_fifo: synchronous power-of-two FIFO with push/pop, full/empty, count.
// Head word is readable combinationally on rd_data.
module hs_fifo
    import hs_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wr_data,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [cnt_w(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/handshaking_master.sv
// Handshake source: FIFO-buffered producer words presented on valid/ready.
// Define HS_MASTER_TIMEOUT_EN to add a sticky stall timeout output.
module handshaking_master
    import hs_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_W,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    full,
    output logic                    empty,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    overflow,
`ifdef HS_MASTER_TIMEOUT_EN
    output logic                    timeout,
`endif
    handshaking_master_if.master    hs
);

    hs_state_t             state;
    hs_state_t             state_n;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] data_q;

    hs_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // A pop reloads the output register; in SEND only after a transfer.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (hs.ready_in) begin
                    if (!empty) pop = 1'b1;
                    else        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) data_q <= head;
            overflow <= wr_en && full;
        end
    end

    assign hs.data_out  = data_q;
    assign hs.valid_out = (state == SEND);

`ifdef HS_MASTER_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SW-1:0] stall;
    logic [SW:0]   stall_inc;
    logic          stall_hit;

    assign stall_inc = {1'b0, stall} + 1'b1;
    assign stall_hit = (stall_inc >= (SW + 1)'(TIMEOUT_CYCLES));

    // Counter saturates at the limit; timeout stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall   <= '0;
            timeout <= 1'b0;
        end else if (state == SEND) begin
            if (hs.ready_in) begin
                stall <= '0;
            end else begin
                stall <= stall_hit ? SW'(TIMEOUT_CYCLES)
                                   : stall_inc[SW-1:0];
                if (stall_hit) timeout <= 1'b1;
            end
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_handshaking_master.sv
// Bench for handshaking_master: vector table, directed sequences,
// and random traffic against a queue-based reference model.
module tb_handshaking_master;
    import hs_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
`ifdef HS_MASTER_TIMEOUT_EN
    logic       timeout;
`endif

    handshaking_master_if #(.DATA_WIDTH(DW)) hs ();

    handshaking_master #(
        .DATA_WIDTH     (DW),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
`ifdef HS_MASTER_TIMEOUT_EN
        .timeout  (timeout),
`endif
        .hs       (hs.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [7:0] m_q[$];
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ovf;
    int         m_stall;
    logic       m_to;

    logic [7:0] dut_xfer[$];
    int         max_count;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        int         ec;
        logic       ef;
        logic       eo;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ovf   = 1'b0;
        m_stall = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic we, input logic [7:0] wd,
                              input logic rdy);
        bit full_pre;
        bit xfer;
        full_pre = (m_q.size() == DEPTH);
        xfer     = m_valid && rdy;
        if (m_valid && !rdy) begin
            m_stall++;
            if (m_stall >= TO) m_to = 1'b1;
        end else if (xfer) begin
            m_stall = 0;
        end
        if (!m_valid || xfer) begin
            if (m_q.size() > 0) begin
                m_data  = m_q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (we && !full_pre) m_q.push_back(wd);
        m_ovf = we && full_pre;
    endtask

    task automatic check_all();
        chk("valid", 32'(hs.valid_out), 32'(m_valid));
        chk("data", 32'(hs.data_out), 32'(m_data));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef HS_MASTER_TIMEOUT_EN
        chk("timeout", 32'(timeout), 32'(m_to));
`endif
        if (int'(count) > max_count) max_count = int'(count);
    endtask

    task automatic cycle(input logic we, input logic [7:0] wd,
                         input logic rdy);
        rst         = 1'b0;
        wr_en       = we;
        wr_data     = wd;
        hs.ready_in = rdy;
        if (hs.valid_out && rdy) dut_xfer.push_back(hs.data_out);
        @(posedge clk);
        model_step(we, wd, rdy);
        #1;
        check_all();
    endtask

    task automatic do_reset(input int n);
        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_data     = 8'h00;
        hs.ready_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_reset();
            #1;
            check_all();
        end
        rst = 1'b0;
    endtask

    initial begin
        // full/overflow then drain, derived by hand
        tbl[0]  = '{1, 8'h01, 0, 0, 8'h00, 1, 0, 0};
        tbl[1]  = '{1, 8'h02, 0, 1, 8'h01, 1, 0, 0};
        tbl[2]  = '{1, 8'h03, 0, 1, 8'h01, 2, 0, 0};
        tbl[3]  = '{1, 8'h04, 0, 1, 8'h01, 3, 0, 0};
        tbl[4]  = '{1, 8'h05, 0, 1, 8'h01, 4, 1, 0};
        tbl[5]  = '{1, 8'h06, 0, 1, 8'h01, 4, 1, 1};
        tbl[6]  = '{0, 8'h00, 0, 1, 8'h01, 4, 1, 0};
        tbl[7]  = '{0, 8'h00, 1, 1, 8'h02, 3, 0, 0};
        tbl[8]  = '{0, 8'h00, 1, 1, 8'h03, 2, 0, 0};
        tbl[9]  = '{0, 8'h00, 1, 1, 8'h04, 1, 0, 0};
        tbl[10] = '{0, 8'h00, 1, 1, 8'h05, 0, 0, 0};
        tbl[11] = '{0, 8'h00, 1, 0, 8'h05, 0, 0, 0};

        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_data     = 8'h00;
        hs.ready_in = 1'b0;
        max_count   = 0;
        model_reset();

        // reset and idle
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            chk("idle_valid", 32'(hs.valid_out), 32'd0);
            chk("idle_data", 32'(hs.data_out), 32'h00);
            chk("idle_empty", 32'(empty), 32'd1);
            chk("idle_count", 32'(count), 32'd0);
        end

        // single transfer with stall
        cycle(1'b1, 8'hD4, 1'b0);
        chk("single_lat0", 32'(hs.valid_out), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            chk("single_valid", 32'(hs.valid_out), 32'd1);
            chk("single_data", 32'(hs.data_out), 32'hD4);
        end
        cycle(1'b0, 8'h00, 1'b1);
        chk("single_done", 32'(hs.valid_out), 32'd0);

        // back-to-back burst
        cycle(1'b1, 8'h4D, 1'b1);
        cycle(1'b1, 8'h00, 1'b1);
        chk("burst0_v", 32'(hs.valid_out), 32'd1);
        chk("burst0_d", 32'(hs.data_out), 32'h4D);
        cycle(1'b1, 8'hFF, 1'b1);
        chk("burst1_v", 32'(hs.valid_out), 32'd1);
        chk("burst1_d", 32'(hs.data_out), 32'h00);
        cycle(1'b0, 8'h00, 1'b1);
        chk("burst2_v", 32'(hs.valid_out), 32'd1);
        chk("burst2_d", 32'(hs.data_out), 32'hFF);
        cycle(1'b0, 8'h00, 1'b1);
        chk("burst_end", 32'(hs.valid_out), 32'd0);

        // full/overflow table
        do_reset(1);
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].we, tbl[i].wd, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 32'(hs.valid_out),
                32'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i), 32'(hs.data_out),
                32'(tbl[i].ed));
            chk($sformatf("tbl%0d_count", i), 32'(count),
                32'(tbl[i].ec));
            chk($sformatf("tbl%0d_full", i), 32'(full),
                32'(tbl[i].ef));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow),
                32'(tbl[i].eo));
        end

        // wrap with simultaneous push/pop
        do_reset(1);
        dut_xfer.delete();
        max_count = 0;
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h10 + i), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("wrap_n", 32'(dut_xfer.size()), 32'd10);
        for (int i = 0; i < 10 && i < dut_xfer.size(); i++)
            chk($sformatf("wrap_w%0d", i), 32'(dut_xfer[i]),
                32'(8'h10 + i));
        chk("wrap_maxcnt", 32'(max_count <= 1), 32'd1);

        // reset mid-operation after a long stall
        do_reset(1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 18; i++) cycle(1'b0, 8'h00, 1'b0);
`ifdef HS_MASTER_TIMEOUT_EN
        chk("timeout_set", 32'(timeout), 32'd1);
`endif
        chk("stall_count", 32'(count), 32'd2);
        do_reset(1);
`ifdef HS_MASTER_TIMEOUT_EN
        chk("timeout_clr", 32'(timeout), 32'd0);
`endif
        chk("rst_valid", 32'(hs.valid_out), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        dut_xfer.delete();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk("no_stale", 32'(hs.valid_out), 32'd0);
        end
        chk("no_stale_xfer", 32'(dut_xfer.size()), 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic we;
            logic rdy;
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1);
            end else begin
                we  = ($urandom_range(0, 3) != 0);
                rdy = (i % 200 < 100) ? ($urandom_range(0, 3) == 0)
                                      : ($urandom_range(0, 3) != 0);
                cycle(we, 8'($urandom), rdy);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/handshaking_master.md
Name: handshaking_master

Overview:
- Upstream source stage for handshaking_slave.
- Buffers words from a local producer in a small FIFO and presents them one at a time on a valid/ready interface (data_out/valid_out -> slave data_in/valid_in; slave ready_out -> ready_in).
- Guarantees data stability while valid is high and supports back-to-back transfers.

Parameters:
- DATA_WIDTH, 8, width of producer and handshake data.
- DEPTH, 4, FIFO entries (power of two, >= 2).
- TIMEOUT_CYCLES, 16, stall limit; used only when HS_MASTER_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  producer write strobe.
- wr_data  in  DATA_WIDTH  producer word.
- full  out  1  FIFO full, combinational from registered state.
- empty  out  1  FIFO empty, combinational from registered state.
- count  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the output register.
- overflow  out  1  one-cycle pulse when wr_en is asserted while full.
- data_out  out  DATA_WIDTH  word presented to slave.
- valid_out  out  1  data_out holds a valid word.
- ready_in  in  1  slave ready.

Behaviour:
- Reset (rst=1 at edge):
  - FIFO pointers and count are 0; full=0, empty=1.
  - overflow=0, valid_out=0, data_out=0, state=IDLE.
  - Reset mid-transfer discards all buffered words and the held word.
- FIFO write:
  - wr_en && !full at an edge stores wr_data and increments count.
  - wr_en && full drops the word and pulses overflow for the next cycle.
  - full is the current registered value; a simultaneous pop does not make room for that write.
- Transfer: completes at an edge where valid_out && ready_in are both 1.
- State machine, 2 states:
  - IDLE: valid_out=0. If !empty at an edge, pop the FIFO head into data_out, set valid_out=1, go to SEND.
  - SEND: valid_out=1. data_out and valid_out are held constant until transfer; ready_in low stalls indefinitely.
    - On transfer with !empty: pop the next word into data_out in the same edge and stay in SEND. valid_out stays high, giving 1 word/cycle throughput.
    - On transfer with empty: valid_out=0, go to IDLE.
- valid_out never depends combinationally on ready_in.
- Latency: wr_en sampled at edge N into an empty, IDLE block -> valid_out=1 after edge N+1.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Pointer wrap: pointers wrap modulo DEPTH; full when count==DEPTH.
- ready_in while valid_out=0: ignored.

Optional Feature:
- Macro: HS_MASTER_TIMEOUT_EN.
- With macro defined:
  - Adds output port timeout (1 bit).
  - A stall counter increments each cycle in SEND with ready_in=0 and clears on transfer or reset.
  - When the counter reaches TIMEOUT_CYCLES, timeout is set sticky until rst. The word is NOT dropped and the handshake continues.
- Without macro: no timeout port, no counter; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package hs_pkg contains:
  - DATA_WIDTH default constant.
  - State enum typedef hs_state_t {IDLE, SEND}.
  - Count-width helper function.
- Sub-module hs_fifo: synchronous FIFO with push, pop, full, empty and count. It is reusable by the slave side later.
- handshaking_master contains the FSM, output register and optional timeout logic.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst 2 cycles, then release with no writes.
  - Required: valid_out=0, data_out=0x00, empty=1, count=0 for 10 cycles.
- Single transfer:
  - Stimulus: write 0xD4 at edge N with ready_in=0.
  - Required: valid_out=1, data_out=0xD4 after N+1, held 5 cycles. Raise ready_in -> valid_out=0 the next cycle.
- Back-to-back burst:
  - Stimulus: write 0x4D, 0x00, 0xFF on consecutive cycles with ready_in=1 constant.
  - Required: data_out sequence 0x4D, 0x00, 0xFF on consecutive cycles with valid_out continuously high, then low.
- Full/overflow:
  - Stimulus: ready_in=0; write 0x01 (loads output), then 0x02..0x05 (fills FIFO), then 0x06.
  - Required: full=1, count=4, overflow pulses once, 0x06 lost. Drain with ready_in=1 -> 0x01..0x05 in order.
- Wrap and simultaneous push/pop:
  - Stimulus: ready_in=1, stream 10 words 0x10..0x19 with one write per cycle.
  - Required: all delivered in order, count never exceeds 1, pointers wrap correctly.
- Reset mid-operation, with and without the macro:
  - Stimulus: 3 words buffered and ready_in=0 held 16 cycles.
  - Required with macro: timeout=1. Assert rst: timeout=0, valid_out=0, empty=1 next cycle, no stale word appears afterward.
